multi_cycle_ctrl: RTL and testbench
===================================

// Module: multi_cycle_ctrl
// PURPOSE
//  Multi-cycle control FSM driving the shared CPU datapath (pc, im/IR, gpr, alu, ext, dm, npc, muxes).
//  Sequences each instruction through IF/ID/EX/MEM/WB and asserts the architectural write strobes only in the owning state.
//  Datapath selects are decoded from the latched IR fields op/funct; retired instructions are counted.
// PARAMETERS
//  ALU_ADD  5'd0  aluop code for addu/lw/sw address
//  ALU_SUB  5'd1  aluop code for subu/beq compare
//  ALU_OR   5'd2  aluop code for ori
//  ALU_SLT  5'd3  aluop code for slt
//  ALU_LUI  5'd4  aluop code for lui (imm32<<16)
// PORTS
//  clock      in   1   system clock, rising edge
//  reset      in   1   asynchronous, active-high
//  op         in   6   IR[31:26], stable from ID onward
//  funct      in   6   IR[5:0]
//  zero       in   1   ALU zero flag (consumed by npc, not here)
//  pc_write   out  1   PC load strobe
//  ir_write   out  1   IR load strobe
//  reg_write  out  1   gpr write strobe
//  mem_write  out  1   dm write strobe
//  aluop      out  5   ALU operation
//  extop      out  1   1=sign-extend, 0=zero-extend imm16
//  RegDst     out  2   0=rt, 1=rd, 2=r31
//  ALUSrc     out  1   0=gpr b, 1=imm32
//  MemtoReg   out  2   0=pc+4, 1=alu c, 2=dm out
//  s          out  2   npc select: 0=pc+4, 1=beq(zero-qualified), 2=j/jal index, 3=jr rs
//  state      out  3   current state, for debug
//  instret    out  32  retired-instruction count
// BEHAVIOUR
//  States: IF=0, ID=1, EX=2, MEM=3, WB=4. state reg resets asynchronously to IF; instret to 0.
//  Strobes are combinational from state and op/funct, forced 0 while reset=1; other outputs are pure decode of op/funct in every state.
//  IF : ir_write=1; -> ID.
//  ID : j: pc_write, s=2 -> IF.  jal: pc_write, s=2, reg_write, RegDst=2, MemtoReg=0 -> IF.
//       jr (op=0,funct=001000): pc_write, s=3 -> IF.  illegal op/funct: pc_write, s=0 -> IF (NOP).  else -> EX.
//  EX : beq: pc_write, s=1 -> IF.  lw/sw -> MEM.  R-type/ori/lui -> WB.
//  MEM: sw: mem_write, pc_write, s=0 -> IF.  lw -> WB.
//  WB : reg_write, pc_write, s=0 -> IF.  R: RegDst=1, MemtoReg=1; ori/lui: RegDst=0, MemtoReg=1; lw: RegDst=0, MemtoReg=2.
//  PC is held until the last cycle of each instruction, so pc+4 link and branch base use current PC.
//  Latency (cycles incl. IF): lw 5; sw, R, ori, lui 4; beq 3; j, jal, jr, illegal 2.
//  Decode: R(000000): addu 100001 ADD, subu 100011 SUB, slt 101010 SLT, ALUSrc=0.
//   ori 001101 OR/extop0/ALUSrc1; lui 001111 LUI/extop0/ALUSrc1; lw 100011, sw 101011 ADD/extop1/ALUSrc1;
//   beq 000100 SUB/extop1/ALUSrc0; j 000010; jal 000011. Unlisted select values = 0.
//  instret += 1 on every clock edge with pc_write=1 (incl. illegal NOP); wraps 32'hFFFFFFFF -> 0.
//  Reset mid-instruction: state -> IF immediately; no strobe fires in the reset cycle; partial instruction discarded.
//  state never leaves 0..4; any other encoding -> IF next edge.
// TESTING
//  Reset held 3 cycles -> state=0, instret=0, all strobes 0; release -> ir_write=1 first cycle.
//  lw (op=100011) -> states 0,1,2,3,4; reg_write only in WB with MemtoReg=2, RegDst=0; instret=1.
//  sw then addu -> mem_write in MEM only (cycle 4); addu reg_write in WB, RegDst=1, aluop=0; instret=2 after 8 cycles.
//  beq/j/jal/jr -> 3/2/2/2 cycles; s=1/2/2/3 on pc_write cycle; jal reg_write with RegDst=2, MemtoReg=0.
//  op=111111 -> 2 cycles, pc_write with s=0, no reg/mem write, instret increments.
//  Assert reset in MEM of sw -> no mem_write, state=IF async; force instret=32'hFFFFFFFF then retire -> 0.

Source files
------------

// File: rtl/multi_cycle_ctrl_if.sv
// Control bundle between the multi-cycle controller and the shared CPU datapath.
// The controller uses the master modport and the datapath uses the slave modport.
interface multi_cycle_ctrl_if;
  logic [5:0]  op;
  logic [5:0]  funct;
  logic        zero;
  logic        pc_write;
  logic        ir_write;
  logic        reg_write;
  logic        mem_write;
  logic [4:0]  aluop;
  logic        extop;
  logic [1:0]  RegDst;
  logic        ALUSrc;
  logic [1:0]  MemtoReg;
  logic [1:0]  s;
  logic [2:0]  state;
  logic [31:0] instret;

  modport master (
    input  op, funct, zero,
    output pc_write, ir_write, reg_write, mem_write,
    output aluop, extop, RegDst, ALUSrc, MemtoReg, s, state, instret
  );

  modport slave (
    output op, funct, zero,
    input  pc_write, ir_write, reg_write, mem_write,
    input  aluop, extop, RegDst, ALUSrc, MemtoReg, s, state, instret
  );
endinterface

// File: rtl/multi_cycle_ctrl.sv
// Multi-cycle IF/ID/EX/MEM/WB controller: write strobes come from the current state,
// datapath selects are a pure decode of the latched op/funct, and retirements are counted.
module multi_cycle_ctrl (
  input  logic              clock,
  input  logic              reset,
  multi_cycle_ctrl_if.master bus
);
  localparam logic [4:0] ALU_ADD = 5'd0;
  localparam logic [4:0] ALU_SUB = 5'd1;
  localparam logic [4:0] ALU_OR  = 5'd2;
  localparam logic [4:0] ALU_SLT = 5'd3;
  localparam logic [4:0] ALU_LUI = 5'd4;

  typedef enum logic [2:0] {
    S_IF  = 3'd0,
    S_ID  = 3'd1,
    S_EX  = 3'd2,
    S_MEM = 3'd3,
    S_WB  = 3'd4
  } state_t;

  state_t      state_q;
  state_t      state_d;
  logic [31:0] instret_count;
  logic        pc_write;

  logic is_r, is_addu, is_subu, is_slt, is_jr, is_ori, is_lui;
  logic is_lw, is_sw, is_beq, is_j, is_jal, is_legal;

  always_comb begin
    is_r     = (bus.op == 6'b000000);
    is_addu  = is_r && (bus.funct == 6'b100001);
    is_subu  = is_r && (bus.funct == 6'b100011);
    is_slt   = is_r && (bus.funct == 6'b101010);
    is_jr    = is_r && (bus.funct == 6'b001000);
    is_ori   = (bus.op == 6'b001101);
    is_lui   = (bus.op == 6'b001111);
    is_lw    = (bus.op == 6'b100011);
    is_sw    = (bus.op == 6'b101011);
    is_beq   = (bus.op == 6'b000100);
    is_j     = (bus.op == 6'b000010);
    is_jal   = (bus.op == 6'b000011);
    is_legal = is_addu | is_subu | is_slt | is_jr | is_ori | is_lui |
               is_lw | is_sw | is_beq | is_j | is_jal;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= S_IF;
    else       state_q <= state_d;
  end

  // Jumps and illegal encodings finish in ID; everything else needs at least EX.
  always_comb begin
    state_d = S_IF;
    case (state_q)
      S_IF:  state_d = S_ID;
      S_ID:  state_d = (is_j | is_jal | is_jr | !is_legal) ? S_IF : S_EX;
      S_EX:  begin
        if (is_beq)              state_d = S_IF;
        else if (is_lw | is_sw)  state_d = S_MEM;
        else                     state_d = S_WB;
      end
      S_MEM: state_d = is_lw ? S_WB : S_IF;
      S_WB:  state_d = S_IF;
      default: state_d = S_IF;
    endcase
  end

  always_comb begin
    pc_write      = 1'b0;
    bus.ir_write  = 1'b0;
    bus.reg_write = 1'b0;
    bus.mem_write = 1'b0;
    if (!reset) begin
      case (state_q)
        S_IF:  bus.ir_write = 1'b1;
        S_ID:  begin
          pc_write      = is_j | is_jal | is_jr | !is_legal;
          bus.reg_write = is_jal;
        end
        S_EX:  pc_write = is_beq;
        S_MEM: begin
          pc_write      = is_sw;
          bus.mem_write = is_sw;
        end
        S_WB:  begin
          pc_write      = 1'b1;
          bus.reg_write = 1'b1;
        end
        default: pc_write = 1'b0;
      endcase
    end
  end

  // Selects depend only on the instruction, so they are already settled in the strobe cycle.
  always_comb begin
    bus.aluop    = ALU_ADD;
    bus.extop    = 1'b0;
    bus.ALUSrc   = 1'b0;
    bus.RegDst   = 2'd0;
    bus.MemtoReg = 2'd0;
    bus.s        = 2'd0;
    if (is_addu | is_subu | is_slt) begin
      bus.RegDst   = 2'd1;
      bus.MemtoReg = 2'd1;
      if (is_subu)     bus.aluop = ALU_SUB;
      else if (is_slt) bus.aluop = ALU_SLT;
    end
    if (is_ori | is_lui) begin
      bus.aluop    = is_ori ? ALU_OR : ALU_LUI;
      bus.ALUSrc   = 1'b1;
      bus.MemtoReg = 2'd1;
    end
    if (is_lw | is_sw) begin
      bus.extop  = 1'b1;
      bus.ALUSrc = 1'b1;
    end
    if (is_lw)  bus.MemtoReg = 2'd2;
    if (is_beq) begin
      bus.aluop = ALU_SUB;
      bus.extop = 1'b1;
      bus.s     = 2'd1;
    end
    if (is_j | is_jal) bus.s = 2'd2;
    if (is_jal)        bus.RegDst = 2'd2;
    if (is_jr)         bus.s = 2'd3;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset)         instret_count <= 32'd0;
    else if (pc_write) instret_count <= instret_count + 32'd1;
  end

  assign bus.pc_write = pc_write;
  assign bus.state    = state_q;
  assign bus.instret  = instret_count;
endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// Randomized scoreboard bench for multi_cycle_ctrl: the driver pushes one expected retirement
// per instruction, and a monitor pops and compares it whenever the DUT strobes pc_write.
module tb_multi_cycle_ctrl;
  logic clock = 1'b0;
  logic reset = 1'b1;

  multi_cycle_ctrl_if bus ();

  multi_cycle_ctrl dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [3:0]  lat;
    logic [2:0]  fin;
    logic [1:0]  s;
    logic        rw;
    logic        mw;
    logic [1:0]  rd;
    logic [1:0]  m2r;
    logic [4:0]  aluop;
    logic        ext;
    logic        src;
    logic [31:0] ic;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_instret = 32'd0;

  // Instruction-level reference: cycle count, retiring stage and datapath settings per opcode.
  function automatic exp_t refModel(input logic [5:0] op, input logic [5:0] funct);
    exp_t e;
    e = '0;
    e.lat = 4'd2;
    e.fin = 3'd1;
    case (op)
      6'h00: begin
        if (funct == 6'h21 || funct == 6'h23 || funct == 6'h2a) begin
          e.lat = 4'd4; e.fin = 3'd4; e.rw = 1'b1; e.rd = 2'd1; e.m2r = 2'd1;
          e.aluop = (funct == 6'h21) ? 5'd0 : (funct == 6'h23) ? 5'd1 : 5'd3;
        end else if (funct == 6'h08) begin
          e.s = 2'd3;
        end
      end
      6'h0d: begin e.lat = 4'd4; e.fin = 3'd4; e.rw = 1'b1; e.m2r = 2'd1; e.aluop = 5'd2; e.src = 1'b1; end
      6'h0f: begin e.lat = 4'd4; e.fin = 3'd4; e.rw = 1'b1; e.m2r = 2'd1; e.aluop = 5'd4; e.src = 1'b1; end
      6'h23: begin e.lat = 4'd5; e.fin = 3'd4; e.rw = 1'b1; e.m2r = 2'd2; e.ext = 1'b1; e.src = 1'b1; end
      6'h2b: begin e.lat = 4'd4; e.fin = 3'd3; e.mw = 1'b1; e.ext = 1'b1; e.src = 1'b1; end
      6'h04: begin e.lat = 4'd3; e.fin = 3'd2; e.s = 2'd1; e.aluop = 5'd1; e.ext = 1'b1; end
      6'h02: e.s = 2'd2;
      6'h03: begin e.s = 2'd2; e.rw = 1'b1; e.rd = 2'd2; end
      default: e.lat = 4'd2;
    endcase
    return e;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  // Called one tick after a rising edge with the DUT in IF; returns aligned the same way.
  task automatic applyStimulus(input logic [5:0] op, input logic [5:0] funct);
    exp_t e;
    bus.op    = op;
    bus.funct = funct;
    bus.zero  = $urandom_range(0, 1) == 1;
    e         = refModel(op, funct);
    e.ic      = exp_instret;
    sb.push_back(e);
    exp_instret = exp_instret + 32'd1;
    repeat (int'(e.lat)) @(posedge clock);
    #1;
  endtask

  initial begin
    int   cyc = 0;
    exp_t e;
    forever begin
      @(negedge clock);
      if (reset) begin
        cyc = 0;
        continue;
      end
      cyc++;
      checkOutput("ir_write", 64'(bus.ir_write), 64'(cyc == 1));
      checkOutput("stray_write", 64'({bus.reg_write, bus.mem_write} & {2{~bus.pc_write}}), 64'd0);
      if (bus.pc_write) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_retire: got pc_write=1 expected no retirement at %0t", $time);
        end else begin
          e = sb.pop_front();
          checkOutput("latency", 64'(cyc), 64'(e.lat));
          checkOutput("retire_state", 64'(bus.state), 64'(e.fin));
          checkOutput("decode",
            64'({bus.s, bus.reg_write, bus.mem_write, bus.RegDst, bus.MemtoReg, bus.aluop, bus.extop, bus.ALUSrc}),
            64'({e.s, e.rw, e.mw, e.rd, e.m2r, e.aluop, e.ext, e.src}));
          checkOutput("instret", 64'(bus.instret), 64'(e.ic));
        end
        cyc = 0;
      end else if (cyc > 8) begin
        checks++;
        errors++;
        $display("[TB] FAIL retire_timeout: got %0d cycles expected at most 5", cyc);
        cyc = 0;
      end
    end
  end

  initial begin
    int k;
    bus.op    = 6'd0;
    bus.funct = 6'd0;
    bus.zero  = 1'b0;
    reset     = 1'b1;
    repeat (3) @(posedge clock);
    @(negedge clock);
    checkOutput("reset_state", 64'(bus.state), 64'd0);
    checkOutput("reset_instret", 64'(bus.instret), 64'd0);
    checkOutput("reset_strobes", 64'({bus.pc_write, bus.ir_write, bus.reg_write, bus.mem_write}), 64'd0);
    @(posedge clock);
    #1 reset = 1'b0;

    applyStimulus(6'h23, 6'h15);
    applyStimulus(6'h2b, 6'h04);
    applyStimulus(6'h00, 6'h21);
    applyStimulus(6'h04, 6'h3c);
    applyStimulus(6'h02, 6'h11);
    applyStimulus(6'h03, 6'h22);
    applyStimulus(6'h00, 6'h08);
    applyStimulus(6'h3f, 6'h3f);
    applyStimulus(6'h00, 6'h23);
    applyStimulus(6'h00, 6'h2a);
    applyStimulus(6'h0d, 6'h01);
    applyStimulus(6'h0f, 6'h02);
    applyStimulus(6'h00, 6'h00);

    for (int n = 0; n < 150; n++) begin
      k = $urandom_range(0, 11);
      case (k)
        0:  applyStimulus(6'h00, 6'h21);
        1:  applyStimulus(6'h00, 6'h23);
        2:  applyStimulus(6'h00, 6'h2a);
        3:  applyStimulus(6'h00, 6'h08);
        4:  applyStimulus(6'h0d, 6'($urandom));
        5:  applyStimulus(6'h0f, 6'($urandom));
        6:  applyStimulus(6'h23, 6'($urandom));
        7:  applyStimulus(6'h2b, 6'($urandom));
        8:  applyStimulus(6'h04, 6'($urandom));
        9:  applyStimulus(6'h02, 6'($urandom));
        10: applyStimulus(6'h03, 6'($urandom));
        default: applyStimulus(6'($urandom), 6'($urandom));
      endcase
    end

    bus.op    = 6'h2b;
    bus.funct = 6'h00;
    repeat (3) @(posedge clock);
    #1 reset = 1'b1;
    #1;
    checkOutput("midreset_state", 64'(bus.state), 64'd0);
    checkOutput("midreset_strobes", 64'({bus.pc_write, bus.mem_write, bus.reg_write}), 64'd0);
    checkOutput("midreset_instret", 64'(bus.instret), 64'd0);
    exp_instret = 32'd0;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;

    applyStimulus(6'h2b, 6'h09);
    applyStimulus(6'h00, 6'h21);

    force dut.instret_count = 32'hFFFF_FFFF;
    #2;
    release dut.instret_count;
    exp_instret = 32'hFFFF_FFFF;
    applyStimulus(6'h02, 6'h00);
    applyStimulus(6'h00, 6'h21);

    repeat (2) @(posedge clock);
    @(negedge clock);
    checkOutput("scoreboard_drained", 64'(sb.size()), 64'd0);
    checkOutput("final_instret", 64'(bus.instret), 64'(exp_instret));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
